// File: rtl/stage_io_port_pkg.sv
// stage_io_port_pkg: shared constants for the byte I/O endpoint
package stage_io_port_pkg;
  localparam logic [7:0] IO_EOF_VALUE = 8'h00;
  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_t;
endpackage

// File: rtl/stage_io_port_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;
  assign full    = count == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Empty FIFO presents zero so the head is never X after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
endmodule

// File: rtl/stage_io_port.sv
// stage_io_port: buffered byte I/O endpoint serving the core's '.' and ',' operations
module stage_io_port
  import stage_io_port_pkg::*;
#(
  parameter int                 D_WIDTH    = 8,
  parameter int                 DEPTH_LOG2 = 2,
  parameter logic [D_WIDTH-1:0] EOF_VALUE  = D_WIDTH'(IO_EOF_VALUE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wce,
  input  logic [D_WIDTH-1:0] wd,
  output logic               wbusy,
  input  logic               rce,
  output logic [D_WIDTH-1:0] rq,
  output logic               rdrdy,
  output logic               tx_valid,
  output logic [D_WIDTH-1:0] tx_data,
  input  logic               tx_ready,
  input  logic               rx_valid,
  input  logic [D_WIDTH-1:0] rx_data,
  output logic               rx_ready,
  input  logic               rx_eof,
  output logic               idle
);
  rd_state_t          state;
  logic               tx_full, tx_empty, rx_full, rx_empty, rx_pop;
  logic [D_WIDTH-1:0] rx_head;
  sync_fifo #(.WIDTH(D_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .reset(reset), .push(wce && !tx_full), .pop(tx_valid && tx_ready),
    .din(wd), .dout(tx_data), .full(tx_full), .empty(tx_empty)
  );
  sync_fifo #(.WIDTH(D_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .reset(reset), .push(rx_valid && rx_ready), .pop(rx_pop),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  assign wbusy    = tx_full;
  assign tx_valid = !tx_empty;
  assign rx_ready = reset && !rx_full;
  assign rx_pop   = !rx_empty && (state == R_WAIT || rce);
  assign idle     = tx_empty && state == R_IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= R_IDLE;
      rq    <= '0;
      rdrdy <= 1'b0;
    end else begin
      rdrdy <= 1'b0;
      if (state == R_WAIT || rce) begin
        if (!rx_empty) begin
          rq    <= rx_head;
          rdrdy <= 1'b1;
          state <= R_IDLE;
        end else if (rx_eof) begin
          rq    <= EOF_VALUE;
          rdrdy <= 1'b1;
          state <= R_IDLE;
        end else begin
          state <= R_WAIT;
        end
      end
    end
endmodule

// File: tb/tb_stage_io_port.sv
// tb_stage_io_port: directed self-checking bench for stage_io_port
module tb_stage_io_port;
  logic       clk = 0, reset = 0;
  logic       wce = 0, rce = 0, tx_ready = 0, rx_valid = 0, rx_eof = 0;
  logic [7:0] wd = 0, rx_data = 0;
  logic       wbusy, rdrdy, tx_valid, rx_ready, idle;
  logic [7:0] rq, tx_data;
  int         tests = 0, fails = 0;

  stage_io_port dut (
    .clk(clk), .reset(reset), .wce(wce), .wd(wd), .wbusy(wbusy), .rce(rce), .rq(rq),
    .rdrdy(rdrdy), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_eof(rx_eof), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    tests++; if ({rq, rdrdy, tx_valid, tx_data, wbusy, rx_ready} !== 20'h0) begin
      fails++; $display("FAIL reset_outputs: got rq=%h rdrdy=%b txv=%b txd=%h wbusy=%b rxr=%b want all 0",
                        rq, rdrdy, tx_valid, tx_data, wbusy, rx_ready); end
    @(negedge clk); reset = 1; #1;
    tests++; if (idle !== 1'b1 || rx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release: got idle=%b rx_ready=%b want 1 1", idle, rx_ready); end
  endtask

  task automatic test_write_single();
    @(negedge clk); tx_ready = 1; wce = 1; wd = 8'h41; #1;
    tests++; if (wbusy !== 1'b0) begin fails++; $display("FAIL ws_wbusy: got %b want 0", wbusy); end
    @(negedge clk); wce = 0;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 || idle !== 1'b0) begin
      fails++; $display("FAIL ws_tx: got v=%b d=%h idle=%b want 1 41 0", tx_valid, tx_data, idle); end
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0 || idle !== 1'b1) begin
      fails++; $display("FAIL ws_pop: got v=%b idle=%b want 0 1", tx_valid, idle); end
    tx_ready = 0;
  endtask

  task automatic test_tx_full();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); wce = 1; wd = 8'(i); #1;
      tests++; if (wbusy !== (i == 5)) begin
        fails++; $display("FAIL full_wbusy%0d: got %b want %b", i, wbusy, i == 5); end
    end
    @(negedge clk); tx_ready = 1;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h01 || wbusy !== 1'b1) begin
      fails++; $display("FAIL full_head: got v=%b d=%h wbusy=%b want 1 01 1", tx_valid, tx_data, wbusy); end
    @(negedge clk);
    tests++; if (tx_data !== 8'h02 || wbusy !== 1'b0) begin
      fails++; $display("FAIL full_after_pop: got d=%h wbusy=%b want 02 0", tx_data, wbusy); end
    @(negedge clk); wce = 0;
    for (int i = 3; i <= 5; i++) begin
      tests++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        fails++; $display("FAIL full_order%0d: got v=%b d=%h want 1 %h", i, tx_valid, tx_data, 8'(i)); end
      @(negedge clk);
    end
    tests++; if (tx_valid !== 1'b0 || idle !== 1'b1) begin
      fails++; $display("FAIL full_drained: got v=%b idle=%b want 0 1", tx_valid, idle); end
    tx_ready = 0;
  endtask

  task automatic test_read_buffered();
    @(negedge clk); rx_valid = 1; rx_data = 8'h2B;
    @(negedge clk); rx_valid = 0; rce = 1;
    tests++; if (rdrdy !== 1'b0) begin fails++; $display("FAIL rb_early: got rdrdy=%b want 0", rdrdy); end
    @(negedge clk); rce = 0;
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h2B) begin
      fails++; $display("FAIL rb_done: got rdrdy=%b rq=%h want 1 2b", rdrdy, rq); end
    @(negedge clk);
    tests++; if (rdrdy !== 1'b0 || rq !== 8'h2B || idle !== 1'b1) begin
      fails++; $display("FAIL rb_hold: got rdrdy=%b rq=%h idle=%b want 0 2b 1", rdrdy, rq, idle); end
  endtask

  task automatic test_read_wait();
    @(negedge clk); rce = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rce = 0;
      tests++; if (rdrdy !== 1'b0 || idle !== 1'b0) begin
        fails++; $display("FAIL rw_wait%0d: got rdrdy=%b idle=%b want 0 0", i, rdrdy, idle); end
    end
    rx_valid = 1; rx_data = 8'h7F;
    @(negedge clk); rx_valid = 0;
    tests++; if (rdrdy !== 1'b0) begin fails++; $display("FAIL rw_push: got rdrdy=%b want 0", rdrdy); end
    @(negedge clk);
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h7F) begin
      fails++; $display("FAIL rw_done: got rdrdy=%b rq=%h want 1 7f", rdrdy, rq); end
    @(negedge clk);
    tests++; if (rdrdy !== 1'b0 || idle !== 1'b1) begin
      fails++; $display("FAIL rw_pulse: got rdrdy=%b idle=%b want 0 1", rdrdy, idle); end
  endtask

  task automatic test_eof();
    @(negedge clk); rx_eof = 1; rce = 1;
    @(negedge clk); rce = 0;
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h00) begin
      fails++; $display("FAIL eof_empty: got rdrdy=%b rq=%h want 1 00", rdrdy, rq); end
    rx_valid = 1; rx_data = 8'h10;
    @(negedge clk); rx_valid = 0; rce = 1;
    @(negedge clk);
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h10) begin
      fails++; $display("FAIL eof_buffered: got rdrdy=%b rq=%h want 1 10", rdrdy, rq); end
    @(negedge clk); rce = 0;
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h00) begin
      fails++; $display("FAIL eof_b2b: got rdrdy=%b rq=%h want 1 00", rdrdy, rq); end
    rx_eof = 0;
    @(negedge clk);
  endtask

  task automatic test_same_cycle_arrival();
    @(negedge clk); rce = 1; rx_valid = 1; rx_data = 8'h55;
    @(negedge clk); rce = 0; rx_valid = 0;
    tests++; if (rdrdy !== 1'b0 || idle !== 1'b0) begin
      fails++; $display("FAIL sc_wait: got rdrdy=%b idle=%b want 0 0", rdrdy, idle); end
    @(negedge clk);
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h55) begin
      fails++; $display("FAIL sc_done: got rdrdy=%b rq=%h want 1 55", rdrdy, rq); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); wce = 1; wd = 8'hAA;
    @(negedge clk); wd = 8'hBB;
    @(negedge clk); wce = 0; rce = 1;
    @(negedge clk); rce = 0;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA || idle !== 1'b0) begin
      fails++; $display("FAIL rm_pre: got v=%b d=%h idle=%b want 1 aa 0", tx_valid, tx_data, idle); end
    #2 reset = 0; #1;
    tests++; if (tx_valid !== 1'b0 || rx_ready !== 1'b0 || wbusy !== 1'b0 || rdrdy !== 1'b0) begin
      fails++; $display("FAIL rm_async: got v=%b rxr=%b wbusy=%b rdrdy=%b want 0 0 0 0",
                        tx_valid, rx_ready, wbusy, rdrdy); end
    @(negedge clk); reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (rdrdy !== 1'b0 || tx_valid !== 1'b0 || idle !== 1'b1) begin
        fails++; $display("FAIL rm_after%0d: got rdrdy=%b v=%b idle=%b want 0 0 1", i, rdrdy, tx_valid, idle); end
    end
    rx_eof = 1; rce = 1;
    @(negedge clk); rce = 0; rx_eof = 0;
    tests++; if (rdrdy !== 1'b1 || rq !== 8'h00) begin
      fails++; $display("FAIL rm_rx_empty: got rdrdy=%b rq=%h want 1 00", rdrdy, rq); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_tx_full();
    test_read_buffered();
    test_read_wait();
    test_eof();
    test_same_cycle_arrival();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
